dpram_port_arbiter: RTL and testbench

Round-robin arbiter that shares one port of a `dpram` instance between `NUM_CLIENTS` requesters (e.g. CPU bus, DMA, debug/loader). It registers the winning request onto the RAM port, acknowledges the winner, and returns read data with a per-client valid strobe. It sits directly in front of one RAM port. The RAM's other port stays dedicated to a single consumer.

---
 rtl/dpram_arb_pkg.sv | 16 +
 rtl/rr_pick.sv | 33 +++
 rtl/dpram_port_arbiter.sv | 97 +++++++++
 tb/tb_dpram_port_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dpram_arb_pkg.sv
// Shared types and helpers for the dpram port arbiter
// and the round-robin picker it builds on.
package dpram_arb_pkg;

   localparam int MAX_CLIENTS = 8;

   typedef logic [2:0] client_idx_t;

   // Pointer increment that wraps at n instead of at the type width.
   function automatic client_idx_t rr_next(input client_idx_t ptr,
                                           input int n);
      if (int'(ptr) >= n - 1) return '0;
      return ptr + 3'd1;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first eligible index
// at or after ptr, searching upward with wrap.
module rr_pick
   import dpram_arb_pkg::*;
#(
   parameter int N = 3
) (
   input  logic [N-1:0] eligible,
   input  client_idx_t  ptr,
   output logic [N-1:0] grant_onehot,
   output client_idx_t  grant_idx,
   output logic         any
);

   always_comb begin
      int idx;
      idx          = 0;
      grant_onehot = '0;
      grant_idx    = '0;
      any          = |eligible;
      // Walk farthest-first so the closest hit overwrites the rest.
      for (int k = N - 1; k >= 0; k--) begin
         idx = int'(ptr) + k;
         if (idx >= N) idx = idx - N;
         if (eligible[idx]) begin
            grant_onehot      = '0;
            grant_onehot[idx] = 1'b1;
            grant_idx         = client_idx_t'(idx);
         end
      end
   end

endmodule

// File: rtl/dpram_port_arbiter.sv
// Round-robin sharing of one dpram port between several clients,
// with registered RAM drive and a one-hot read-return tag pipeline.
module dpram_port_arbiter
   import dpram_arb_pkg::*;
#(
   parameter int NUM_CLIENTS = 3,
   parameter int addr_width  = 8,
   parameter int data_width  = 8
) (
   input  logic                              clock,
   input  logic                              reset,
   input  logic [NUM_CLIENTS-1:0]            req,
   input  logic [NUM_CLIENTS-1:0]            we,
   input  logic [NUM_CLIENTS*addr_width-1:0] addr,
   input  logic [NUM_CLIENTS*data_width-1:0] wdata,
   output logic [NUM_CLIENTS-1:0]            ack,
   output logic [NUM_CLIENTS-1:0]            rvalid,
   output logic [data_width-1:0]             rdata,
   output logic [addr_width-1:0]             ram_address,
   output logic [data_width-1:0]             ram_data,
   output logic                              ram_enable,
   output logic                              ram_cs,
   output logic                              ram_wren,
   input  logic [data_width-1:0]             ram_q
);

   logic [NUM_CLIENTS-1:0] eligible;
   logic [NUM_CLIENTS-1:0] grant_onehot;
   logic [NUM_CLIENTS-1:0] tag1;
   logic [NUM_CLIENTS-1:0] tag2;
   client_idx_t            grant_idx;
   client_idx_t            rr_ptr;
   logic                   any;
   logic                   sel_we;
   logic [addr_width-1:0]  sel_addr;
   logic [data_width-1:0]  sel_data;

   // A client acked this cycle is still holding req; skip it once.
   assign eligible = req & ~ack;

   rr_pick #(
      .N(NUM_CLIENTS)
   ) u_pick (
      .eligible     (eligible),
      .ptr          (rr_ptr),
      .grant_onehot (grant_onehot),
      .grant_idx    (grant_idx),
      .any          (any)
   );

   always_comb begin
      sel_addr = '0;
      sel_data = '0;
      sel_we   = |(we & grant_onehot);
      for (int i = 0; i < NUM_CLIENTS; i++) begin
         if (grant_onehot[i]) begin
            sel_addr = addr[i*addr_width +: addr_width];
            sel_data = wdata[i*data_width +: data_width];
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         rr_ptr      <= '0;
         ack         <= '0;
         ram_address <= '0;
         ram_data    <= '0;
         ram_enable  <= 1'b0;
         ram_cs      <= 1'b0;
         ram_wren    <= 1'b0;
         tag1        <= '0;
         tag2        <= '0;
      end else begin
         ack  <= any ? grant_onehot : '0;
         tag1 <= (any && !sel_we) ? grant_onehot : '0;
         tag2 <= tag1;
         if (any) begin
            ram_address <= sel_addr;
            ram_data    <= sel_data;
            ram_enable  <= 1'b1;
            ram_cs      <= 1'b1;
            ram_wren    <= sel_we;
            rr_ptr      <= rr_next(grant_idx, NUM_CLIENTS);
         end else begin
            ram_enable  <= 1'b0;
            ram_cs      <= 1'b0;
            ram_wren    <= 1'b0;
         end
      end
   end

   // RAM output is registered inside the RAM; forward it directly.
   assign rvalid = tag2;
   assign rdata  = ram_q;

endmodule

// File: tb/tb_dpram_port_arbiter.sv
// Randomised scoreboard bench for dpram_port_arbiter with a
// behavioural RAM and a transaction-level reference model.
module tb_dpram_port_arbiter;

   localparam int N  = 3;
   localparam int AW = 8;
   localparam int DW = 8;

   logic            clk;
   logic            rst;
   logic [N-1:0]    req;
   logic [N-1:0]    we;
   logic [N*AW-1:0] addr;
   logic [N*DW-1:0] wdata;
   logic [N-1:0]    ack;
   logic [N-1:0]    rvalid;
   logic [DW-1:0]   rdata;
   logic [AW-1:0]   ram_address;
   logic [DW-1:0]   ram_data;
   logic            ram_enable;
   logic            ram_cs;
   logic            ram_wren;
   logic [DW-1:0]   ram_q;

   dpram_port_arbiter #(
      .NUM_CLIENTS(N),
      .addr_width (AW),
      .data_width (DW)
   ) dut (
      .clock       (clk),
      .reset       (rst),
      .req         (req),
      .we          (we),
      .addr        (addr),
      .wdata       (wdata),
      .ack         (ack),
      .rvalid      (rvalid),
      .rdata       (rdata),
      .ram_address (ram_address),
      .ram_data    (ram_data),
      .ram_enable  (ram_enable),
      .ram_cs      (ram_cs),
      .ram_wren    (ram_wren),
      .ram_q       (ram_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int compared   = 0;
   int mismatched = 0;
   int edge_n     = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h expected %0h at edge %0d",
                  nm, act, exp, edge_n);
      end
   endtask

   function automatic logic [7:0] seed(input int i);
      if (i == 'h12) return 8'hA5;
      return 8'(i * 29 + 7);
   endfunction

   // Behavioural RAM: read-before-write, registered q.
   logic [DW-1:0] ram [256];
   bit            ram_fresh = 1'b1;
   always @(posedge clk) begin
      if (ram_fresh) begin
         for (int i = 0; i < 256; i++) ram[i] <= seed(i);
         ram_fresh <= 1'b0;
      end else if (ram_enable && ram_cs) begin
         if (ram_wren) ram[ram_address] <= ram_data;
         ram_q <= ram[ram_address];
      end
   end

   // Reference model: grant order, memory image, expected events.
   typedef struct {
      int          tag;
      logic [N-1:0] ack;
      logic        en;
      logic        wr;
      logic [7:0]  a;
      logic [7:0]  d;
   } exp_t;
   typedef struct {
      int          tag;
      logic [N-1:0] oh;
      logic [7:0]  d;
   } rd_t;

   exp_t        eq[$];
   rd_t         rq[$];
   logic [7:0]  m_mem [256];
   int          m_rr;
   logic [N-1:0] m_prev;
   logic [7:0]  m_addr;
   logic [7:0]  m_data;

   always @(posedge clk) begin : model
      exp_t e;
      rd_t  r;
      int   w;
      logic [N-1:0] elig;
      edge_n = edge_n + 1;
      if (edge_n == 1)
         for (int i = 0; i < 256; i++) m_mem[i] = seed(i);
      e.tag = edge_n;
      e.ack = '0;
      e.en  = 1'b0;
      e.wr  = 1'b0;
      if (rst) begin
         m_rr   = 0;
         m_prev = '0;
         m_addr = '0;
         m_data = '0;
         rq.delete();
      end else begin
         elig = req & ~m_prev;
         w = -1;
         for (int k = 0; k < N; k++)
            if (w < 0 && elig[(m_rr + k) % N]) w = (m_rr + k) % N;
         if (w >= 0) begin
            e.ack    = '0;
            e.ack[w] = 1'b1;
            e.en     = 1'b1;
            e.wr     = we[w];
            m_addr   = addr[w*AW +: AW];
            m_data   = wdata[w*DW +: DW];
            if (we[w]) begin
               m_mem[m_addr] = m_data;
            end else begin
               r.tag   = edge_n + 1;
               r.oh    = '0;
               r.oh[w] = 1'b1;
               r.d     = m_mem[m_addr];
               rq.push_back(r);
            end
            m_rr = (w + 1) % N;
         end
         m_prev = e.ack;
      end
      e.a = m_addr;
      e.d = m_data;
      eq.push_back(e);
   end

   // Monitor: compare DUT outputs away from the active edge.
   always @(negedge clk) begin : monitor
      exp_t e;
      rd_t  r;
      if (edge_n > 0) begin
         if (eq.size() > 0 && eq[0].tag == edge_n) begin
            e = eq.pop_front();
            chk("ack", ack, e.ack);
            chk("ram_enable", ram_enable, e.en);
            chk("ram_cs", ram_cs, e.en);
            chk("ram_wren", ram_wren, e.wr);
            chk("ram_address", ram_address, e.a);
            chk("ram_data", ram_data, e.d);
         end
         if (rq.size() > 0 && rq[0].tag == edge_n) begin
            r = rq.pop_front();
            chk("rvalid", rvalid, r.oh);
            chk("rdata", rdata, r.d);
         end else begin
            chk("rvalid_idle", rvalid, '0);
         end
      end
   end

   // Client drivers.
   logic [N-1:0] creq;
   logic [N-1:0] cwe;
   logic [N-1:0] hold;
   logic [7:0]   caddr [N];
   logic [7:0]   cwd   [N];

   task automatic drive();
      req = creq;
      we  = cwe;
      for (int i = 0; i < N; i++) begin
         addr[i*AW +: AW]  = caddr[i];
         wdata[i*DW +: DW] = cwd[i];
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++)
         if (ack[i] && !hold[i]) creq[i] = 1'b0;
      drive();
   endtask

   task automatic set_req(input int i, input logic w,
                          input logic [7:0] a, input logic [7:0] d);
      creq[i]  = 1'b1;
      cwe[i]   = w;
      caddr[i] = a;
      cwd[i]   = d;
      drive();
   endtask

   task automatic issue(input int i, input logic w,
                        input logic [7:0] a, input logic [7:0] d);
      bit got;
      got = 1'b0;
      set_req(i, w, a, d);
      for (int n = 0; n < 20 && !got; n++) begin
         tick();
         got = ack[i];
      end
      if (!got) begin
         chk("ack_timeout", 32'd0, 32'd1);
         creq[i] = 1'b0;
         drive();
      end
   endtask

   initial begin
      rst  = 1'b1;
      creq = '0;
      cwe  = '0;
      hold = '0;
      for (int i = 0; i < N; i++) begin
         caddr[i] = '0;
         cwd[i]   = '0;
      end
      drive();

      // Contention from reset: all clients hold req.
      hold = '1;
      for (int i = 0; i < N; i++) set_req(i, 1'b0, 8'(8'h40 + i), 8'h00);
      tick();
      tick();
      rst = 1'b0;
      repeat (9) tick();
      hold = '0;
      creq = '0;
      drive();
      repeat (3) tick();

      // Single read of preloaded location.
      issue(1, 1'b0, 8'h12, 8'h00);
      repeat (3) tick();

      // Write then back-to-back read of the same address.
      issue(0, 1'b1, 8'h34, 8'h5A);
      issue(0, 1'b0, 8'h34, 8'h00);
      repeat (3) tick();

      // Wrap and skip: pointer lands on 2, only client 0 requests.
      issue(1, 1'b0, 8'h05, 8'h00);
      issue(0, 1'b0, 8'h06, 8'h00);
      repeat (3) tick();

      // Reset asserted in the ack cycle of a read.
      issue(2, 1'b0, 8'h12, 8'h00);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      repeat (3) tick();

      // Idle stretch.
      repeat (10) tick();

      // Randomised traffic with occasional resets.
      for (int c = 0; c < 600; c++) begin
         tick();
         if ($urandom_range(0, 199) == 0) begin
            rst  = 1'b1;
            creq = '0;
         end else begin
            rst = 1'b0;
            for (int i = 0; i < N; i++)
               if (!creq[i] && $urandom_range(0, 99) < 55)
                  set_req(i, 1'($urandom_range(0, 1)),
                          8'($urandom_range(0, 15)),
                          8'($urandom));
         end
         drive();
      end

      rst  = 1'b0;
      creq = '0;
      drive();
      repeat (6) tick();
      chk("rvalid_drain", rq.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               compared, mismatched);
      $finish;
   end

endmodule
